bpm_beat_generator: RTL

//   Sits directly downstream of bpm_trigger_value and consumes its 34-bit beat period (clock cycles per

---
 rtl/bpm_beat_generator.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bpm_beat_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bpm_beat_generator
// Purpose  : Metronome beat, accent and click generator driven by a filtered
//            beat period in clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module bpm_beat_generator #(
   parameter int STABLE_CYCLES = 64,
   parameter int CLICK_LEN     = 16,
   parameter int ACCENT_LEN    = 32,
   parameter int MIN_PERIOD    = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic        i_restart,
   input  logic [33:0] i_trigger_value,
   input  logic [3:0]  i_beats_per_bar,
   output logic        o_beat_pulse,
   output logic        o_accent_pulse,
   output logic [3:0]  o_beat_index,
   output logic        o_click,
   output logic        o_running
);

   localparam int c_stab_w  = $clog2(STABLE_CYCLES + 1);
   localparam int c_click_w = $clog2(ACCENT_LEN + 1);
   localparam logic [c_stab_w-1:0]  c_stab_max   = c_stab_w'(STABLE_CYCLES - 1);
   localparam logic [c_stab_w-1:0]  c_stab_one   = c_stab_w'(1);
   localparam logic [33:0]          c_min_period = 34'(MIN_PERIOD);
   localparam logic [c_click_w-1:0] c_click_len  = c_click_w'(CLICK_LEN);
   localparam logic [c_click_w-1:0] c_accent_len = c_click_w'(ACCENT_LEN);
   localparam logic [c_click_w-1:0] c_click_one  = c_click_w'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [33:0]           r_candidate;
   logic [c_stab_w-1:0]   r_stable_cnt;
   logic [33:0]           r_period;
   logic [33:0]           r_count;
   logic [33:0]           w_next_count;
   logic [3:0]            r_beat_index;
   logic [3:0]            w_next_index;
   logic [3:0]            w_step_index;
   logic                  w_fire;
   logic                  w_fire_ok;
   logic                  w_accent;
   logic                  w_exit;
   logic                  w_valid;
   logic [33:0]           w_period_m1;
   logic                  r_beat_pulse;
   logic                  r_accent_pulse;
   logic [c_click_w-1:0]  r_click_cnt;
   logic                  r_click;

   // A new period is only adopted after it has held still long enough.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_candidate  <= '0;
         r_stable_cnt <= '0;
         r_period     <= '0;
      end else begin
         r_candidate <= i_trigger_value;
         if (i_trigger_value != r_candidate)
            r_stable_cnt <= '0;
         else if (r_stable_cnt != c_stab_max)
            r_stable_cnt <= r_stable_cnt + c_stab_one;
         if ((r_stable_cnt == c_stab_max) && (r_candidate != r_period))
            r_period <= r_candidate;
      end
   end

   assign w_valid     = (r_period >= c_min_period);
   assign w_period_m1 = r_period - 34'd1;

   // Wrapping with >= also catches an index left stranded by a shrunk bar length.
   always_comb begin
      w_step_index = r_beat_index + 4'd1;
      if (i_beats_per_bar <= 4'd1)
         w_step_index = 4'd0;
      else if (({1'b0, r_beat_index} + 5'd1) >= {1'b0, i_beats_per_bar})
         w_step_index = 4'd0;
   end

   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count;
      w_next_index = r_beat_index;
      w_fire       = 1'b0;
      w_exit       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_next_count = '0;
            w_next_index = '0;
            if (i_enable && w_valid) begin
               w_next_state = S_START;
               w_fire       = 1'b1;
            end
         end
         S_START: begin
            w_next_count = 34'd1;
            w_next_state = S_RUN;
         end
         S_RUN: begin
            if (!i_enable || !w_valid) begin
               w_next_state = S_IDLE;
               w_next_count = '0;
               w_next_index = '0;
               w_exit       = 1'b1;
            end else if (i_restart) begin
               w_next_state = S_START;
               w_next_count = '0;
               w_next_index = '0;
               w_fire       = 1'b1;
            end else if (r_count >= w_period_m1) begin
               w_next_count = '0;
               w_next_index = w_step_index;
               w_fire       = 1'b1;
            end else begin
               w_next_count = r_count + 34'd1;
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_count = '0;
            w_next_index = '0;
         end
      endcase
   end

   // Suppressing a fire right after a pulse keeps strobes from ever abutting.
   assign w_fire_ok = w_fire && !r_beat_pulse;
   assign w_accent  = w_fire_ok && (w_next_index == 4'd0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_count        <= '0;
         r_beat_index   <= '0;
         r_beat_pulse   <= 1'b0;
         r_accent_pulse <= 1'b0;
         r_click_cnt    <= '0;
         r_click        <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_count        <= w_next_count;
         r_beat_index   <= w_next_index;
         r_beat_pulse   <= w_fire_ok;
         r_accent_pulse <= w_accent;
         if (w_exit) begin
            r_click_cnt <= '0;
            r_click     <= 1'b0;
         end else begin
            if (w_fire_ok)
               r_click_cnt <= w_accent ? c_accent_len : c_click_len;
            else if (r_click_cnt != '0)
               r_click_cnt <= r_click_cnt - c_click_one;
            r_click <= (r_click_cnt != '0);
         end
      end
   end

   assign o_beat_pulse   = r_beat_pulse;
   assign o_accent_pulse = r_accent_pulse;
   assign o_beat_index   = r_beat_index;
   assign o_click        = r_click;
   assign o_running      = (r_state == S_RUN);

endmodule
`default_nettype wire
